// File: rtl/stream_pkg.sv
// Shared definitions for the byte-stream input chain: default widths, the
// packed word record and the bit-reversal helper used by PACKER_BITREV_EN builds.
package stream_pkg;

  localparam int unsigned DEF_IN_W  = 8;
  localparam int unsigned DEF_BYTES = 2;
  localparam int unsigned DEF_OUT_W = DEF_IN_W * DEF_BYTES;
  localparam int unsigned DEF_IDX_W = $clog2(DEF_BYTES);

  typedef struct packed {
    logic [DEF_OUT_W-1:0] data;
    logic                 last;
    logic                 pad;
  } stream_word_t;

  function automatic logic [DEF_IN_W-1:0] bitrev(input logic [DEF_IN_W-1:0] b);
    logic [DEF_IN_W-1:0] r;
    r = '0;
    for (int unsigned i = 0; i < DEF_IN_W; i++) begin
      r[i] = b[DEF_IN_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/stream_out_reg.sv
// Single-entry ready/valid output register. A load may coincide with a drain;
// payload is held stable while valid is stalled.
module stream_out_reg #(
  parameter int unsigned W = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         load_i,
  input  logic [W-1:0] load_data_i,
  input  logic         load_last_i,
  input  logic         load_pad_i,
  input  logic         drain_i,
  output logic         can_load_o,
  output logic         valid_o,
  output logic [W-1:0] data_o,
  output logic         last_o,
  output logic         pad_o
);

  logic         valid_q, valid_d;
  logic [W-1:0] data_q, data_d;
  logic         last_q, last_d;
  logic         pad_q, pad_d;

  assign can_load_o = !valid_q || drain_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    last_d  = last_q;
    pad_d   = pad_q;
    if (load_i) begin
      valid_d = 1'b1;
      data_d  = load_data_i;
      last_d  = load_last_i;
      pad_d   = load_pad_i;
    end else if (valid_q && drain_i) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
      pad_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      last_q  <= last_d;
      pad_q   <= pad_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;
  assign pad_o   = pad_q;

endmodule

// File: rtl/stream_byte_packer.sv
// Packs BYTES little-endian bytes into one output word, padding short final words.
// Optional macro PACKER_BITREV_EN bit-reverses every accepted byte before packing.
module stream_byte_packer
  import stream_pkg::*;
#(
  parameter int unsigned IN_W  = DEF_IN_W,
  parameter int unsigned BYTES = DEF_BYTES,
  parameter int unsigned OUT_W = DEF_OUT_W
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last,
  output logic             out_pad
);

  localparam int unsigned IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);

  logic             en_q;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [OUT_W-1:0] acc_q, acc_d;
  logic [IN_W-1:0]  byte_w;
  logic [OUT_W-1:0] byte_sh;
  logic [OUT_W-1:0] word;
  logic             accept, complete, can_load, pad;

`ifdef PACKER_BITREV_EN
  assign byte_w = bitrev(in_data);
`else
  assign byte_w = in_data;
`endif

  // in_ready held low through reset and for the release edge itself
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) en_q <= 1'b0;
    else          en_q <= 1'b1;
  end

  assign in_ready = en_q && can_load;
  assign accept   = in_valid && in_ready;
  assign complete = accept && ((idx_q == LAST_IDX) || in_last);
  assign byte_sh  = OUT_W'(byte_w) << (IN_W * idx_q);
  assign word     = acc_q | byte_sh;
  assign pad      = in_last && (idx_q != LAST_IDX);

  always_comb begin
    idx_d = idx_q;
    acc_d = acc_q;
    if (complete) begin
      idx_d = '0;
      acc_d = '0;
    end else if (accept) begin
      idx_d = idx_q + IDX_W'(1);
      acc_d = word;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      idx_q <= '0;
      acc_q <= '0;
    end else begin
      idx_q <= idx_d;
      acc_q <= acc_d;
    end
  end

  stream_out_reg #(
    .W(OUT_W)
  ) u_out_reg (
    .clk_i      (clock),
    .rst_ni     (reset_n),
    .load_i     (complete),
    .load_data_i(word),
    .load_last_i(in_last),
    .load_pad_i (pad),
    .drain_i    (out_ready),
    .can_load_o (can_load),
    .valid_o    (out_valid),
    .data_o     (out_data),
    .last_o     (out_last),
    .pad_o      (out_pad)
  );

endmodule

// File: tb/tb_stream_byte_packer.sv
// Directed and randomised bench for stream_byte_packer (default parameters).
module tb_stream_byte_packer;
  import stream_pkg::*;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [7:0]  in_data = '0;
  logic        in_last = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_data;
  logic        out_last;
  logic        out_pad;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] rx[$];
  logic [31:0] exp_q[$];
  bit          tx_done;

  always #5 clock = ~clock;

  stream_byte_packer #(
    .IN_W (8),
    .BYTES(2),
    .OUT_W(16)
  ) dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .out_pad  (out_pad)
  );

  // Output transfers happen at the posedge following this sample.
  always @(negedge clock) begin
    if (reset_n && out_valid && out_ready) begin
      stream_word_t w;
      w = '{data: out_data, last: out_last, pad: out_pad};
      rx.push_back(32'(w));
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] rb(input logic [7:0] b);
`ifdef PACKER_BITREV_EN
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
`else
    return b;
`endif
  endfunction

  function automatic logic [31:0] wd(input logic [15:0] d, input logic l, input logic p);
    stream_word_t w;
    w = '{data: d, last: l, pad: p};
    return 32'(w);
  endfunction

  task automatic cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic l, output int stalls);
    bit done;
    done     = 0;
    stalls   = 0;
    in_valid = 1'b1;
    in_data  = b;
    in_last  = l;
    while (!done) begin
      @(negedge clock);
      if (in_ready) done = 1;
      else begin
        stalls++;
        if (stalls > 300) begin
          check("send_timeout", 32'(stalls), 32'd0);
          done = 1;
        end
      end
    end
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [31:0] exp);
    logic [31:0] g;
    g = (rx.size() != 0) ? rx.pop_front() : 32'hFFFF_FFFF;
    check(tag, g, exp);
  endtask

  initial begin
    int st, tot, nv, bad, nlast;
    logic [7:0] b[2048];

    // reset state
    cycles(2);
    @(negedge clock);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'd0);
    check("rst_out_last_pad", {30'd0, out_last, out_pad}, 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    @(negedge clock);
    check("rel_in_ready_same", 32'(in_ready), 32'd0);
    @(negedge clock);
    check("rel_in_ready_next", 32'(in_ready), 32'd1);
    @(posedge clock); #1;

    // 1: back-to-back at full rate
    out_ready = 1'b1;
    tot = 0;
    send_byte(8'h04, 0, st); tot += st;
    send_byte(8'h01, 0, st); tot += st;
    send_byte(8'h7F, 0, st); tot += st;
    send_byte(8'h80, 0, st); tot += st;
    idle();
    cycles(4);
    check("t1_stalls", 32'(tot), 32'd0);
    check("t1_count", 32'(rx.size()), 32'd2);
    pop_check("t1_w0", wd({rb(8'h01), rb(8'h04)}, 0, 0));
    pop_check("t1_w1", wd({rb(8'h80), rb(8'h7F)}, 0, 0));

    // 2: short final word, then restart at idx 0
    send_byte(8'hAA, 0, st);
    send_byte(8'hBB, 0, st);
    send_byte(8'hCC, 1, st);
    send_byte(8'hDD, 0, st);
    send_byte(8'hEE, 0, st);
    idle();
    cycles(4);
    check("t2_count", 32'(rx.size()), 32'd3);
    pop_check("t2_w0", wd({rb(8'hBB), rb(8'hAA)}, 0, 0));
    pop_check("t2_pad", wd({8'h00, rb(8'hCC)}, 1, 1));
    pop_check("t2_restart", wd({rb(8'hEE), rb(8'hDD)}, 0, 0));

    // 3: downstream stall for 10 cycles while 6 bytes are offered
    out_ready = 1'b0;
    nv = 0;
    bad = 0;
    fork
      begin
        for (int i = 0; i < 6; i++) send_byte(8'h10 + 8'(i), 0, st);
        idle();
      end
      begin
        repeat (10) begin
          @(negedge clock);
          if (out_valid) begin
            nv++;
            if (out_data !== {rb(8'h11), rb(8'h10)} || in_ready !== 1'b0) bad++;
          end
        end
        @(posedge clock); #1;
        out_ready = 1'b1;
      end
    join
    cycles(4);
    check("t3_stall_cycles", 32'(nv), 32'd8);
    check("t3_hold_violations", 32'(bad), 32'd0);
    check("t3_count", 32'(rx.size()), 32'd3);
    pop_check("t3_w0", wd({rb(8'h11), rb(8'h10)}, 0, 0));
    pop_check("t3_w1", wd({rb(8'h13), rb(8'h12)}, 0, 0));
    pop_check("t3_w2", wd({rb(8'h15), rb(8'h14)}, 0, 0));

    // 4: reset after one byte of a word
    send_byte(8'h55, 0, st);
    idle();
    reset_n = 1'b0;
    @(negedge clock);
    check("t4_rst_valid", 32'(out_valid), 32'd0);
    check("t4_rst_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    reset_n = 1'b1;
    cycles(2);
    check("t4_no_output", 32'(rx.size()), 32'd0);
    send_byte(8'h11, 0, st);
    send_byte(8'h22, 0, st);
    idle();
    cycles(4);
    check("t4_count", 32'(rx.size()), 32'd1);
    pop_check("t4_w0", wd({rb(8'h22), rb(8'h11)}, 0, 0));

    // 5: bit ordering of the pin bus
    send_byte(8'h01, 0, st);
    send_byte(8'h80, 0, st);
    idle();
    cycles(4);
`ifdef PACKER_BITREV_EN
    pop_check("t5_bitrev", wd(16'h0180, 0, 0));
`else
    pop_check("t5_plain", wd(16'h8001, 0, 0));
`endif

    // 6: random traffic against golden pairing
    rx.delete();
    for (int i = 0; i < 2048; i++) b[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 1024; i++)
      exp_q.push_back(wd({rb(b[2*i+1]), rb(b[2*i])}, (i == 1023), 0));
    tx_done = 0;
    fork
      begin
        for (int i = 0; i < 2048; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            idle();
            cycles(1);
          end
          send_byte(b[i], (i == 2047), st);
        end
        idle();
        tx_done = 1;
      end
      begin
        while (!tx_done) begin
          @(posedge clock); #1;
          out_ready = 1'($urandom_range(0, 1));
        end
      end
    join
    out_ready = 1'b1;
    cycles(6);
    check("t6_count", 32'(rx.size()), 32'd1024);
    nlast = 0;
    foreach (rx[i]) if (rx[i][1]) nlast++;
    check("t6_last_count", 32'(nlast), 32'd1);
    for (int i = 0; i < 1024; i++) pop_check("t6_word", exp_q[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
